// File: rtl/hazard_interlock_id_if.sv
// Signal bundle between the ID-stage decode (master) and the hazard interlock (slave).
// Also carries the interlock's FSM state so checkers can observe it directly.
interface hazard_interlock_id_if #(
    parameter int REG_W  = 5,
    parameter int STAT_W = 16
);
    logic [REG_W-1:0]  rs_id;
    logic [REG_W-1:0]  rt_id;
    logic              use_rs_id;
    logic              use_rt_id;
    logic [REG_W-1:0]  dest_id;
    logic              mem_rd_id;
    logic              branch_id;
    logic              flush_id;
    logic              hold;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              lw_stall_ex;
    logic              Branch_stall_forwarding;
    logic [STAT_W-1:0] stall_count;
    logic [1:0]        fsm_state;

    // No valid/ready pair: the ID fields describe whatever sits in IF/ID this cycle,
    // and hold=1 freezes every consumer and producer of the bundle for that cycle.
    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, dest_id, mem_rd_id,
               branch_id, flush_id, hold,
        input  stall_if, stall_id, bubble_ex, lw_stall_ex,
               Branch_stall_forwarding, stall_count, fsm_state
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, dest_id, mem_rd_id,
               branch_id, flush_id, hold,
        output stall_if, stall_id, bubble_ex, lw_stall_ex,
               Branch_stall_forwarding, stall_count, fsm_state
    );
endinterface

// File: rtl/hazard_interlock_id.sv
// ID-stage load-use / branch-operand interlock with an EX/MEM shadow pipe.
// Optional stall statistics counter built only when HAZARD_STATS_EN is defined.
module hazard_interlock_id #(
    parameter int REG_W  = 5,
    parameter int STAT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_interlock_id_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [REG_W-1:0]  ex_dest_q, mem_dest_q;
    logic              ex_ld_q, mem_ld_q;
    logic              lw_flag_q, br_flag_q;
    logic              lw_flag_d, br_flag_d;
    logic              flush;
    logic              rs_live, rt_live;
    logic              ex_hit, mem_hit;
    logic [1:0]        need;
    logic              stall;

    assign flush   = bus.flush_id & ~bus.hold;
    assign rs_live = bus.use_rs_id && (bus.rs_id != '0);
    assign rt_live = bus.use_rt_id && (bus.rt_id != '0);
    assign ex_hit  = (rs_live && (bus.rs_id == ex_dest_q)) ||
                     (rt_live && (bus.rt_id == ex_dest_q));
    assign mem_hit = (rs_live && (bus.rs_id == mem_dest_q)) ||
                     (rt_live && (bus.rt_id == mem_dest_q));

    // Branches compare in ID so they also wait on non-load EX results and on loads in MEM.
    always_comb begin
        need = 2'd0;
        if (bus.branch_id) begin
            if (ex_hit && ex_ld_q) begin
                need = 2'd2;
            end else if (ex_hit || (mem_hit && mem_ld_q)) begin
                need = 2'd1;
            end
        end else if (ex_hit && ex_ld_q) begin
            need = 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        lw_flag_d = 1'b0;
        br_flag_d = 1'b0;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                STALL2: begin
                    stall   = 1'b1;
                    state_d = STALL1;
                end
                RUN, STALL1: begin
                    stall = (need != 2'd0);
                    if (need == 2'd2) begin
                        state_d = STALL2;
                    end else if (need == 2'd1) begin
                        state_d = STALL1;
                    end else begin
                        state_d = RUN;
                    end
                    // STALL1 with nothing left to wait for is the release cycle.
                    if ((state_q == STALL1) && (need == 2'd0)) begin
                        lw_flag_d = ~bus.branch_id;
                        br_flag_d = bus.branch_id;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ex_dest_q  <= '0;
            ex_ld_q    <= 1'b0;
            mem_dest_q <= '0;
            mem_ld_q   <= 1'b0;
            lw_flag_q  <= 1'b0;
            br_flag_q  <= 1'b0;
        end else if (!bus.hold) begin
            state_q    <= state_d;
            mem_dest_q <= ex_dest_q;
            mem_ld_q   <= ex_ld_q;
            if (stall || flush) begin
                ex_dest_q <= '0;
                ex_ld_q   <= 1'b0;
            end else begin
                ex_dest_q <= bus.dest_id;
                ex_ld_q   <= bus.mem_rd_id;
            end
            lw_flag_q <= lw_flag_d;
            br_flag_q <= br_flag_d;
        end
    end

    assign bus.stall_if                = stall;
    assign bus.stall_id                = stall;
    assign bus.bubble_ex               = stall;
    assign bus.lw_stall_ex             = lw_flag_q;
    assign bus.Branch_stall_forwarding = br_flag_q;
    assign bus.fsm_state               = state_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!bus.hold && stall && (count_q != '1)) begin
            count_q <= count_q + STAT_W'(1);
        end
    end

    assign bus.stall_count = count_q;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_hazard_interlock_id.sv
// Directed bench for hazard_interlock_id: instruction-level model, per-cycle compare,
// plus literal expectations at the key cycles of each hazard scenario.
module tb_hazard_interlock_id;
    localparam int REG_W  = 5;
    localparam int STAT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_interlock_id_if #(.REG_W(REG_W), .STAT_W(STAT_W)) bus ();
    hazard_interlock_id #(.REG_W(REG_W), .STAT_W(STAT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

`ifdef HAZARD_STATS_EN
    hazard_interlock_id_if #(.REG_W(REG_W), .STAT_W(2)) bus2 ();
    hazard_interlock_id #(.REG_W(REG_W), .STAT_W(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );
    assign bus2.rs_id     = bus.rs_id;
    assign bus2.rt_id     = bus.rt_id;
    assign bus2.use_rs_id = bus.use_rs_id;
    assign bus2.use_rt_id = bus.use_rt_id;
    assign bus2.dest_id   = bus.dest_id;
    assign bus2.mem_rd_id = bus.mem_rd_id;
    assign bus2.branch_id = bus.branch_id;
    assign bus2.flush_id  = bus.flush_id;
    assign bus2.hold      = bus.hold;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // ---------------- instruction encoding helpers ----------------
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       urs;
        logic       urt;
        logic       ld;
        logic       br;
    } instr_t;

    function automatic instr_t nop();
        return '0;
    endfunction
    function automatic instr_t lw(input int d, input int base);
        instr_t i = '0;
        i.rs = base[4:0]; i.urs = 1'b1; i.rt = d[4:0]; i.dest = d[4:0]; i.ld = 1'b1;
        return i;
    endfunction
    function automatic instr_t add(input int d, input int s, input int t);
        instr_t i = '0;
        i.rs = s[4:0]; i.rt = t[4:0]; i.urs = 1'b1; i.urt = 1'b1; i.dest = d[4:0];
        return i;
    endfunction
    function automatic instr_t addi(input int d, input int s);
        instr_t i = '0;
        i.rs = s[4:0]; i.urs = 1'b1; i.rt = d[4:0]; i.dest = d[4:0];
        return i;
    endfunction
    function automatic instr_t sw(input int base, input int data);
        instr_t i = '0;
        i.rs = base[4:0]; i.rt = data[4:0]; i.urs = 1'b1; i.urt = 1'b1;
        return i;
    endfunction
    function automatic instr_t beq(input int s, input int t);
        instr_t i = '0;
        i.rs = s[4:0]; i.rt = t[4:0]; i.urs = 1'b1; i.urt = 1'b1; i.br = 1'b1;
        return i;
    endfunction

    // ---------------- behavioural model ----------------
    // Instructions in EX/MEM are tracked as {dest, is_load}; the ID instruction carries a
    // countdown of stall cycles still owed, re-derived from the rules once it reaches zero.
    logic [4:0] m_ex_dest, m_mem_dest;
    logic       m_ex_ld, m_mem_ld;
    int         m_left;
    logic       m_prev_stall, m_lw, m_br;
    int         m_count;

    logic ex_dep, mem_dep, e_flush, e_stall, e_release;
    int   e_need, e_left;

    always_comb begin
        ex_dep  = (m_ex_dest != 5'd0) &&
                  ((bus.use_rs_id && bus.rs_id == m_ex_dest) || (bus.use_rt_id && bus.rt_id == m_ex_dest));
        mem_dep = (m_mem_dest != 5'd0) &&
                  ((bus.use_rs_id && bus.rs_id == m_mem_dest) || (bus.use_rt_id && bus.rt_id == m_mem_dest));
        e_need = 0;
        if (ex_dep && m_ex_ld) e_need = bus.branch_id ? 2 : 1;
        else if (bus.branch_id && (ex_dep || (mem_dep && m_mem_ld))) e_need = 1;
        e_left    = (m_left > 0) ? m_left : e_need;
        e_flush   = bus.flush_id && !bus.hold;
        e_stall   = !e_flush && (e_left > 0);
        e_release = m_prev_stall && !e_stall && !e_flush;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex_dest    <= '0;
            m_ex_ld      <= 1'b0;
            m_mem_dest   <= '0;
            m_mem_ld     <= 1'b0;
            m_left       <= 0;
            m_prev_stall <= 1'b0;
            m_lw         <= 1'b0;
            m_br         <= 1'b0;
            m_count      <= 0;
        end else if (!bus.hold) begin
            m_left       <= e_stall ? e_left - 1 : 0;
            m_prev_stall <= e_stall;
            m_lw         <= e_release && !bus.branch_id;
            m_br         <= e_release && bus.branch_id;
            m_mem_dest   <= m_ex_dest;
            m_mem_ld     <= m_ex_ld;
            m_ex_dest    <= (e_stall || e_flush) ? 5'd0 : bus.dest_id;
            m_ex_ld      <= (e_stall || e_flush) ? 1'b0 : bus.mem_rd_id;
            m_count      <= m_count + (e_stall ? 1 : 0);
        end
    end

    function automatic logic [31:0] sat_count(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("stall_if", 32'(bus.stall_if), 32'(e_stall));
            check("stall_id", 32'(bus.stall_id), 32'(e_stall));
            check("bubble_ex", 32'(bus.bubble_ex), 32'(e_stall));
            check("lw_stall_ex", 32'(bus.lw_stall_ex), 32'(m_lw));
            check("branch_stall_fwd", 32'(bus.Branch_stall_forwarding), 32'(m_br));
            check("flags_exclusive", 32'(bus.lw_stall_ex & bus.Branch_stall_forwarding), 32'd0);
`ifdef HAZARD_STATS_EN
            check("stall_count", 32'(bus.stall_count), sat_count(m_count, STAT_W));
            check("stall_count_w2", 32'(bus2.stall_count), sat_count(m_count, 2));
`else
            check("stall_count", 32'(bus.stall_count), 32'd0);
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic step(input instr_t i, input bit fl, input bit hd);
        @(posedge clk);
        #1;
        bus.rs_id     = i.rs;
        bus.rt_id     = i.rt;
        bus.use_rs_id = i.urs;
        bus.use_rt_id = i.urt;
        bus.dest_id   = i.dest;
        bus.mem_rd_id = i.ld;
        bus.branch_id = i.br;
        bus.flush_id  = fl;
        bus.hold      = hd;
        @(negedge clk);
        #1;
    endtask

    task automatic s(input instr_t i);
        step(i, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_stall_if", 32'(bus.stall_if), 32'd0);
        check("rst_bubble_ex", 32'(bus.bubble_ex), 32'd0);
        check("rst_fsm", 32'(bus.fsm_state), 32'd0);
        check("rst_lw_flag", 32'(bus.lw_stall_ex), 32'd0);
        check("rst_br_flag", 32'(bus.Branch_stall_forwarding), 32'd0);
        check("rst_count", 32'(bus.stall_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rs_id = '0; bus.rt_id = '0; bus.use_rs_id = 1'b0; bus.use_rt_id = 1'b0;
        bus.dest_id = '0; bus.mem_rd_id = 1'b0; bus.branch_id = 1'b0;
        bus.flush_id = 1'b0; bus.hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // lw r3 ; add r4,r3,r5 -> one stall, then lw flag with add in EX
        s(lw(3, 1));
        check("lu_no_early_stall", 32'(bus.stall_if), 32'd0);
        s(add(4, 3, 5));
        check("lu_stall_if", 32'(bus.stall_if), 32'd1);
        check("lu_bubble", 32'(bus.bubble_ex), 32'd1);
        s(add(4, 3, 5));
        check("lu_release", 32'(bus.stall_if), 32'd0);
        check("lu_fsm_stall1", 32'(bus.fsm_state), 32'd1);
        s(nop());
        check("lu_flag", 32'(bus.lw_stall_ex), 32'd1);
        check("lu_no_br_flag", 32'(bus.Branch_stall_forwarding), 32'd0);
        s(nop());
        check("lu_flag_one_cycle", 32'(bus.lw_stall_ex), 32'd0);

        // lw r3 ; beq r3,r0 -> two stalls, then branch flag
        s(lw(3, 1));
        s(beq(3, 0));
        check("lb_stall_a", 32'(bus.stall_id), 32'd1);
        s(beq(3, 0));
        check("lb_stall_b", 32'(bus.stall_id), 32'd1);
        check("lb_fsm_stall2", 32'(bus.fsm_state), 32'd2);
        s(beq(3, 0));
        check("lb_release", 32'(bus.stall_id), 32'd0);
        s(nop());
        check("lb_br_flag", 32'(bus.Branch_stall_forwarding), 32'd1);
        check("lb_no_lw_flag", 32'(bus.lw_stall_ex), 32'd0);
        s(nop());
        check("lb_br_flag_off", 32'(bus.Branch_stall_forwarding), 32'd0);

        // add r7 ; beq r7,r2 -> one stall
        s(add(7, 1, 1));
        s(beq(7, 2));
        check("ab_stall", 32'(bus.stall_if), 32'd1);
        s(beq(7, 2));
        check("ab_release", 32'(bus.stall_if), 32'd0);
        s(nop());
        check("ab_br_flag", 32'(bus.Branch_stall_forwarding), 32'd1);

        // load in MEM feeding a branch -> one stall
        s(lw(6, 1));
        s(nop());
        s(beq(6, 2));
        check("mb_stall", 32'(bus.stall_if), 32'd1);
        s(beq(6, 2));
        check("mb_release", 32'(bus.stall_if), 32'd0);
        s(nop());
        check("mb_br_flag", 32'(bus.Branch_stall_forwarding), 32'd1);

        // r0 never hazards; unused rt never hazards; sw data operand does
        s(lw(0, 1));
        s(add(4, 0, 0));
        check("r0_no_stall", 32'(bus.stall_if), 32'd0);
        s(lw(3, 1));
        s(addi(3, 1));
        check("unused_rt_no_stall", 32'(bus.stall_if), 32'd0);
        s(lw(9, 1));
        s(sw(1, 9));
        check("sw_rt_stall", 32'(bus.stall_if), 32'd1);
        s(sw(1, 9));
        s(nop());
        check("sw_flag", 32'(bus.lw_stall_ex), 32'd1);

        // hold during detection and during the flag cycle
        s(lw(3, 1));
        repeat (3) begin
            step(add(4, 3, 5), 1'b0, 1'b1);
            check("hold_stall_frozen", 32'(bus.stall_if), 32'd1);
        end
        step(add(4, 3, 5), 1'b0, 1'b0);
        check("hold_stall_live", 32'(bus.stall_if), 32'd1);
        s(add(4, 3, 5));
        check("hold_release", 32'(bus.stall_if), 32'd0);
        step(nop(), 1'b0, 1'b1);
        check("hold_flag_frozen", 32'(bus.lw_stall_ex), 32'd1);
        step(nop(), 1'b0, 1'b0);
        check("hold_flag_live", 32'(bus.lw_stall_ex), 32'd1);
        s(nop());
        check("hold_flag_off", 32'(bus.lw_stall_ex), 32'd0);

        // flush during the first stall cycle after detection
        s(lw(3, 1));
        s(beq(3, 0));
        check("fl_detect", 32'(bus.stall_if), 32'd1);
        step(beq(3, 0), 1'b1, 1'b0);
        check("fl_drop", 32'(bus.stall_if), 32'd0);
        check("fl_drop_bubble", 32'(bus.bubble_ex), 32'd0);
        s(nop());
        check("fl_fsm_run", 32'(bus.fsm_state), 32'd0);
        check("fl_no_br_flag", 32'(bus.Branch_stall_forwarding), 32'd0);
        s(nop());
        check("fl_no_flag_late", 32'(bus.Branch_stall_forwarding), 32'd0);

        // flush beats a freshly detected hazard
        s(lw(3, 1));
        step(add(4, 3, 5), 1'b1, 1'b0);
        check("flb_no_stall", 32'(bus.stall_if), 32'd0);
        s(nop());
        check("flb_no_flag", 32'(bus.lw_stall_ex), 32'd0);
        check("flb_fsm_run", 32'(bus.fsm_state), 32'd0);

        // back-to-back: lw r3 ; lw r6,(r3) ; add r7,r6
        s(lw(3, 1));
        s(lw(6, 3));
        check("bb_stall1", 32'(bus.stall_if), 32'd1);
        s(lw(6, 3));
        check("bb_release1", 32'(bus.stall_if), 32'd0);
        s(add(7, 6, 0));
        check("bb_stall2", 32'(bus.stall_if), 32'd1);
        check("bb_flag1", 32'(bus.lw_stall_ex), 32'd1);
        s(add(7, 6, 0));
        check("bb_release2", 32'(bus.stall_if), 32'd0);
        check("bb_flag_gap", 32'(bus.lw_stall_ex), 32'd0);
        s(nop());
        check("bb_flag2", 32'(bus.lw_stall_ex), 32'd1);

        // reset mid-stall, then the pair restarts cleanly
        s(lw(3, 1));
        s(add(4, 3, 5));
        check("rs_mid_stall", 32'(bus.stall_if), 32'd1);
        do_reset();
        s(add(4, 3, 5));
        check("rs_restart_clear", 32'(bus.stall_if), 32'd0);
        s(lw(3, 1));
        s(add(4, 3, 5));
        check("rs_restart_stall", 32'(bus.stall_if), 32'd1);
        s(add(4, 3, 5));
        s(nop());
        check("rs_restart_flag", 32'(bus.lw_stall_ex), 32'd1);

        // five load-use pairs from a clean reset
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s(lw(3, 1));
            s(add(4, 3, 5));
            s(add(4, 3, 5));
            s(nop());
        end
`ifdef HAZARD_STATS_EN
        check("stats_five", 32'(bus.stall_count), 32'd5);
        check("stats_saturate_w2", 32'(bus2.stall_count), 32'd3);
`else
        check("stats_absent", 32'(bus.stall_count), 32'd0);
`endif
        s(nop());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
